// File: rtl/flag_accum_pkg.sv
// Shared definitions for the FP exception flag accumulator: flag bit layout
// and trap state encoding.
package flag_accum_pkg;

    localparam int WFLAG     = 5;
    localparam int DIVZERO   = 4;
    localparam int INVALID   = 3;
    localparam int INEXACT   = 2;
    localparam int OVERFLOW  = 1;
    localparam int UNDERFLOW = 0;

    localparam int CNT_SEL_W = 3;
    // Enough for a per-cycle count of up to 8 channels.
    localparam int INC_W     = 4;

    typedef enum logic [1:0] {
        TRAP_IDLE = 2'd0,
        TRAP_PEND = 2'd1,
        TRAP_ACKD = 2'd2
    } trap_state_t;

endpackage

// File: rtl/flag_accum_chan.sv
// Per-channel exception flag formation: turns raw FP result conditions into
// the architectural flag vector for one channel (all zero when not valid).
module flag_chan
    import flag_accum_pkg::*;
(
    input  logic             valid,
    input  logic             invalid,
    input  logic             divzero,
    input  logic             overflow,
    input  logic             inexact,
    input  logic             underflow,
    input  logic             tiny,
    input  logic             special,
    output logic [WFLAG-1:0] flags
);

    always_comb begin
        flags = '0;
        if (valid) begin
            flags[DIVZERO]   = divzero & ~special;
            flags[INVALID]   = invalid;
            flags[INEXACT]   = ~special & (inexact | underflow | overflow);
            flags[OVERFLOW]  = ~special & overflow;
            // Underflow is only reported for tiny results that did not overflow.
            flags[UNDERFLOW] = ~special & tiny & underflow & ~overflow;
        end
    end

endmodule

// File: rtl/flag_accum.sv
// FP exception flag accumulator: per-cycle flags, sticky flags and a trap FSM.
// Optional per-flag event counters are built when FLAG_ACCUM_COUNT_EN is defined.
module flag_accum
    import flag_accum_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_invalid,
    input  logic [NCH-1:0]       in_divzero,
    input  logic [NCH-1:0]       in_overflow,
    input  logic [NCH-1:0]       in_inexact,
    input  logic [NCH-1:0]       in_underflow,
    input  logic [NCH-1:0]       in_tiny,
    input  logic [NCH-1:0]       in_special,
    input  logic                 clr,
    input  logic [WFLAG-1:0]     clr_mask,
    input  logic [WFLAG-1:0]     trap_en,
    input  logic                 irq_ack,
    output logic [WFLAG-1:0]     flags_now,
    output logic [WFLAG-1:0]     sticky,
    output logic                 irq,
    output logic [WFLAG-1:0]     irq_cause,
`ifdef FLAG_ACCUM_COUNT_EN
    input  logic [CNT_SEL_W-1:0] cnt_sel,
    output logic [CNT_W-1:0]     cnt_val,
`endif
    output logic [1:0]           state_dbg
);

    logic [WFLAG-1:0] chan_flags [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        flag_chan u_chan (
            .valid     (in_valid[c]),
            .invalid   (in_invalid[c]),
            .divzero   (in_divzero[c]),
            .overflow  (in_overflow[c]),
            .inexact   (in_inexact[c]),
            .underflow (in_underflow[c]),
            .tiny      (in_tiny[c]),
            .special   (in_special[c]),
            .flags     (chan_flags[c])
        );
    end

    logic [WFLAG-1:0] flags_now_d, flags_now_q;
    logic [WFLAG-1:0] sticky_d, sticky_q;
    logic [WFLAG-1:0] cause_d, cause_q;
    logic [WFLAG-1:0] hit;
    logic             irq_d, irq_q;
    trap_state_t      state_d, state_q;

    always_comb begin
        flags_now_d = '0;
        for (int c = 0; c < NCH; c++) begin
            flags_now_d = flags_now_d | chan_flags[c];
        end
        // Clear is applied before the OR, so a set always wins over a clear.
        sticky_d = (sticky_q & ~(clr ? clr_mask : '0)) | flags_now_q;
    end

    assign hit = flags_now_q & trap_en;

    // Trap FSM next-state; irq is registered from the next state so it is
    // always the decode of the current state.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            TRAP_IDLE: begin
                if (hit != '0) begin
                    state_d = TRAP_PEND;
                    cause_d = hit;
                end
            end
            TRAP_PEND: begin
                if (irq_ack) begin
                    state_d = TRAP_ACKD;
                    cause_d = hit;
                end else begin
                    cause_d = cause_q | hit;
                end
            end
            TRAP_ACKD: begin
                cause_d = cause_q | hit;
                state_d = (cause_d != '0) ? TRAP_PEND : TRAP_IDLE;
            end
            default: begin
                state_d = TRAP_IDLE;
                cause_d = '0;
            end
        endcase
        irq_d = (state_d == TRAP_PEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_now_q <= '0;
            sticky_q    <= '0;
            cause_q     <= '0;
            irq_q       <= 1'b0;
            state_q     <= TRAP_IDLE;
        end else begin
            flags_now_q <= flags_now_d;
            sticky_q    <= sticky_d;
            cause_q     <= cause_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
        end
    end

    assign flags_now = flags_now_q;
    assign sticky    = sticky_q;
    assign irq       = irq_q;
    assign irq_cause = cause_q;
    assign state_dbg = state_q;

`ifdef FLAG_ACCUM_COUNT_EN
    localparam logic [CNT_W+INC_W-1:0] CNT_MAX = {{INC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [INC_W-1:0]       inc_d [WFLAG];
    logic [INC_W-1:0]       inc_q [WFLAG];
    logic [CNT_W-1:0]       cnt_d [WFLAG];
    logic [CNT_W-1:0]       cnt_q [WFLAG];
    logic [CNT_W-1:0]       cnt_base [WFLAG];
    logic [CNT_W+INC_W-1:0] cnt_sum [WFLAG];

    // Per-flag channel counts travel alongside flags_now, so a counter
    // advances in the same cycle as the sticky bit it shadows.
    always_comb begin
        for (int f = 0; f < WFLAG; f++) begin
            inc_d[f] = '0;
            for (int c = 0; c < NCH; c++) begin
                inc_d[f] = inc_d[f] + INC_W'(chan_flags[c][f]);
            end
            cnt_base[f] = (clr && clr_mask[f]) ? '0 : cnt_q[f];
            cnt_sum[f]  = {{INC_W{1'b0}}, cnt_base[f]} + {{CNT_W{1'b0}}, inc_q[f]};
            cnt_d[f]    = (cnt_sum[f] > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[f][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < WFLAG; f++) begin
            if (reset) begin
                inc_q[f] <= '0;
                cnt_q[f] <= '0;
            end else begin
                inc_q[f] <= inc_d[f];
                cnt_q[f] <= cnt_d[f];
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        for (int f = 0; f < WFLAG; f++) begin
            if (cnt_sel == CNT_SEL_W'(f)) begin
                cnt_val = cnt_q[f];
            end
        end
    end
`endif

endmodule

// File: doc/flag_accum.md
FLAG_ACCUM -- requirements
Module: flag_accum

Interface
REQ-001 Parameter NCH, default 4, number of parallel FP result channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-flag event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  NCH  per-channel result-valid strobe.
REQ-006 in_invalid, in_divzero, in_overflow, in_inexact, in_underflow, in_tiny, in_special  input  NCH each  raw per-channel exception conditions.
REQ-007 clr  input  1  sticky/counter clear strobe.
REQ-008 clr_mask  input  WFLAG  flag bits cleared when clr=1.
REQ-009 trap_en  input  WFLAG  per-flag trap enable.
REQ-010 irq_ack  input  1  trap acknowledge.
REQ-011 flags_now  output  WFLAG  registered OR of this cycle's channel flags.
REQ-012 sticky  output  WFLAG  accumulated exception flags.
REQ-013 irq  output  1  trap request.
REQ-014 irq_cause  output  WFLAG  trapped flags pending acknowledge.
REQ-015 cnt_sel  input  3  counter select (flag index); cnt_val  output  CNT_W  selected counter (FLAG_ACCUM_COUNT_EN only).

Function
REQ-016 Per channel c with in_valid[c]=1 the block SHALL form: DIVZERO=in_divzero&~special; INVALID=in_invalid; INEXACT=~special&(inexact|underflow|overflow); OVERFLOW=~special&overflow; UNDERFLOW=~special&tiny&underflow&~overflow; all bits 0 when in_valid[c]=0.
REQ-017 flags_now SHALL equal the OR over channels of REQ-016, registered; latency 1 cycle from inputs.
REQ-018 sticky SHALL update each cycle as (sticky & ~(clr ? clr_mask : 0)) | flags_now; latency 2 cycles from inputs; set wins over simultaneous clear of the same bit.
REQ-019 Trap FSM states IDLE, PEND, ACKD; hit = flags_now & trap_en.
REQ-020 IDLE: hit!=0 -> PEND, irq_cause<=hit; else stay.
REQ-021 PEND: irq=1; irq_cause<=irq_cause|hit; irq_ack=1 -> ACKD, irq_cause<=hit (captures same-cycle hit only).
REQ-022 ACKD: irq=0 for exactly one cycle; irq_cause<=irq_cause|hit; next state PEND if resulting irq_cause!=0, else IDLE.
REQ-023 irq_ack in IDLE or ACKD SHALL be ignored; trap_en changes affect only new hits, never clear pending irq_cause.
REQ-024 irq SHALL be a registered decode of state (irq=1 iff PEND).

Reset
REQ-025 reset SHALL force flags_now=0, sticky=0, irq_cause=0, state=IDLE (irq=0), all counters=0, overriding clr and all inputs in that cycle.
REQ-026 Reset mid-PEND SHALL drop irq the following cycle with no ACKD cycle.

Configuration
REQ-027 Macro FLAG_ACCUM_COUNT_EN defined: per-flag counters, each incremented by the number of channels raising that flag in the flags_now cycle, saturating at 2^CNT_W-1; clr zeroes counters selected by clr_mask (increment wins same cycle, counter loads increment value); cnt_val = counter[cnt_sel], 0 for cnt_sel>=WFLAG.
REQ-028 Macro undefined: no counters, no cnt_sel/cnt_val ports; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold WFLAG=5 and bit indices DIVZERO=4, INVALID=3, INEXACT=2, OVERFLOW=1, UNDERFLOW=0, plus the trap-state enum.
REQ-030 Per-channel combinational flag formation (REQ-016) SHALL be one sub-module flag_chan, instantiated NCH times.

Verification
REQ-031 ch0 valid, overflow=1, inexact=0 -> flags_now=5'b00110 at +1, sticky=5'b00110 at +2.
REQ-032 ch1 valid, underflow=tiny=1, special=1 -> flags_now=0; same with special=0 -> 5'b00101.
REQ-033 trap_en=5'b01000, ch2 invalid -> irq=1 at +2, irq_cause=5'b01000; irq_ack -> irq=0 one cycle, IDLE.
REQ-034 sticky=5'b11111, clr=1 clr_mask=5'b11111 while ch0 sets INEXACT -> sticky=5'b00100.
REQ-035 COUNT_EN, CNT_W=4, NCH=4: all channels inexact for 4 cycles -> INEXACT counter 4,8,12,15 (saturated).
REQ-036 Hit arrives in ACKD cycle -> irq re-asserts next cycle with irq_cause=that hit.
